// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Decodes the immediate field and format code of RV32 instruction words. Each
// decoded result is stored in a small in-order output buffer with a
// valid/ready handshake on both sides.
//
// Ports
//   clk          - single clock, rising-edge active
//   rst_n        - asynchronous active-low reset
//   in_valid     - instruction present on in_instr
//   in_ready     - block accepts the instruction this cycle
//   in_instr     - raw 32-bit instruction word
//   flush        - synchronous discard of all buffered entries
//   out_valid    - head entry valid
//   out_ready    - consumer takes the head entry
//   out_imm      - sign-extended immediate of the head entry (XLEN bits)
//   out_fmt      - format code of the head entry (0 R,1 I,2 S,3 B,4 U,5 J,7 bad)
//   out_illegal  - head entry opcode unrecognised
//   ill_cnt      - saturating count of accepted illegal instructions
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [7:0]      ill_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Entry layout: {illegal, fmt[2:0], imm[XLEN-1:0]}
    localparam int EW = XLEN + 4;
    localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ONE_C   = PW'(1);

    // Immediate/format decoder; the 32-bit immediate is sign-extended to XLEN.
    function automatic logic [EW-1:0] decode(input logic [31:0] instr);
        logic [31:0] imm32;
        logic [2:0]  fmt;
        logic        ill;
        imm32 = 32'd0;
        fmt   = 3'd7;
        ill   = 1'b0;
        case (instr[6:0])
            7'b0110011: begin
                imm32 = 32'd0;
                fmt   = 3'd0;
            end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                imm32 = {{20{instr[31]}}, instr[31:20]};
                fmt   = 3'd1;
            end
            7'b0100011: begin
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt   = 3'd2;
            end
            7'b1100011: begin
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
                fmt   = 3'd3;
            end
            7'b0110111, 7'b0010111: begin
                imm32 = {instr[31:12], 12'd0};
                fmt   = 3'd4;
            end
            7'b1101111: begin
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
                fmt   = 3'd5;
            end
            default: begin
                imm32 = 32'd0;
                fmt   = 3'd7;
                ill   = 1'b1;
            end
        endcase
        return {ill, fmt, XLEN'($signed(imm32))};
    endfunction

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [7:0]    r_ill_cnt;
    logic [EW-1:0] w_dec;
    logic          w_push;
    logic          w_pop;

    // Handshake qualification; a pop during flush is discarded.
    always_comb begin
        w_dec     = decode(in_instr);
        in_ready  = (r_count < DEPTH_C) && !flush;
        out_valid = (r_count != {(PW+1){1'b0}});
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready && !flush;
    end

    // Head entry drives the outputs straight from the storage registers.
    always_comb begin
        {out_illegal, out_fmt, out_imm} = r_mem[r_rd_ptr];
        ill_cnt = r_ill_cnt;
    end

    // Pointer and occupancy bookkeeping; flush returns everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else if (flush) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_C) ? {PW{1'b0}} : r_wr_ptr + ONE_C;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_C) ? {PW{1'b0}} : r_rd_ptr + ONE_C;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{PW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so all outputs read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {EW{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= w_dec;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Saturating illegal-instruction counter; unaffected by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ill_cnt <= 8'd0;
        end else if (w_push && w_dec[EW-1] && (r_ill_cnt != 8'hFF)) begin
            r_ill_cnt <= r_ill_cnt + 8'd1;
        end else begin
            r_ill_cnt <= r_ill_cnt;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Directed bench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64, both
// DEPTH=2) share the same stimulus; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a;
    logic        out_valid_a;
    logic [31:0] out_imm_a;
    logic [2:0]  out_fmt_a;
    logic        out_illegal_a;
    logic [7:0]  ill_cnt_a;

    logic        in_ready_b;
    logic        out_valid_b;
    logic [63:0] out_imm_b;
    logic [2:0]  out_fmt_b;
    logic        out_illegal_b;
    logic [7:0]  ill_cnt_b;

    int n_assert;
    int n_fail;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_imm(out_imm_a), .out_fmt(out_fmt_a),
        .out_illegal(out_illegal_a), .ill_cnt(ill_cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_imm(out_imm_b), .out_fmt(out_fmt_b),
        .out_illegal(out_illegal_b), .ill_cnt(ill_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
        check("rst_out_imm",   {32'd0, out_imm_a},   64'd0);
        check("rst_out_fmt",   {61'd0, out_fmt_a},   64'd0);
        check("rst_ill_cnt",   {56'd0, ill_cnt_a},   64'd0);
        #9;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready",  {63'd0, in_ready_a},  64'd1);

        // Format decodes, latency of one cycle
        push(32'hFE000EE3);
        check("b_valid",  {63'd0, out_valid_a}, 64'd1);
        check("b_imm32",  {32'd0, out_imm_a},   64'h0000_0000_FFFF_FFFC);
        check("b_fmt",    {61'd0, out_fmt_a},   64'd3);
        check("b_imm64",  out_imm_b,            64'hFFFF_FFFF_FFFF_FFFC);
        pop();
        check("b_drained", {63'd0, out_valid_a}, 64'd0);

        push(32'h8000006F);
        check("j_imm32",  {32'd0, out_imm_a},   64'h0000_0000_FFF0_0000);
        check("j_fmt",    {61'd0, out_fmt_a},   64'd5);
        pop();

        push(32'h12345037);
        check("u_imm32",  {32'd0, out_imm_a},   64'h0000_0000_1234_5000);
        check("u_fmt",    {61'd0, out_fmt_a},   64'd4);
        check("u_ill",    {63'd0, out_illegal_a}, 64'd0);
        pop();

        push(32'h80000037);
        check("u64_imm",  out_imm_b,            64'hFFFF_FFFF_8000_0000);
        check("u64_fmt",  {61'd0, out_fmt_b},   64'd4);
        pop();

        push(32'hFFF00013);
        check("i64_imm",  out_imm_b,            64'hFFFF_FFFF_FFFF_FFFF);
        check("i64_fmt",  {61'd0, out_fmt_b},   64'd1);
        check("i32_imm",  {32'd0, out_imm_a},   64'h0000_0000_FFFF_FFFF);
        pop();

        // Backpressure and ordering: A=R-type, B=store -8, C=LUI, D=addi -1
        in_valid = 1'b1;
        in_instr = 32'h00B50533;
        tick();
        check("bp_rdy_after_a", {63'd0, in_ready_a}, 64'd1);
        in_instr = 32'hFE512C23;
        tick();
        check("bp_rdy_after_b", {63'd0, in_ready_a}, 64'd0);
        in_instr = 32'h12345037;
        tick();
        check("bp_c_held_rdy",  {63'd0, in_ready_a}, 64'd0);
        check("bp_head_a_fmt",  {61'd0, out_fmt_a},  64'd0);
        check("bp_head_a_imm",  {32'd0, out_imm_a},  64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_head_b_imm",  {32'd0, out_imm_a},  64'h0000_0000_FFFF_FFF8);
        check("bp_head_b_fmt",  {61'd0, out_fmt_a},  64'd2);
        check("bp_rdy_one",     {63'd0, in_ready_a}, 64'd1);
        tick();
        check("bp_head_c_imm",  {32'd0, out_imm_a},  64'h0000_0000_1234_5000);
        check("bp_head_c_fmt",  {61'd0, out_fmt_a},  64'd4);
        in_instr = 32'hFFF00013;
        tick();
        check("bp_head_d_imm",  {32'd0, out_imm_a},  64'h0000_0000_FFFF_FFFF);
        check("bp_hold_valid",  {63'd0, out_valid_a}, 64'd1);
        check("bp_hold_ready",  {63'd0, in_ready_a},  64'd1);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("bp_empty",       {63'd0, out_valid_a}, 64'd0);

        // Illegal opcode
        push(32'h0000007F);
        check("ill_flag", {63'd0, out_illegal_a}, 64'd1);
        check("ill_fmt",  {61'd0, out_fmt_a},     64'd7);
        check("ill_imm",  {32'd0, out_imm_a},     64'd0);
        check("ill_cnt1", {56'd0, ill_cnt_a},     64'd1);

        // Flush with one entry held and an illegal word offered
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        flush     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("fl_in_ready", {63'd0, in_ready_a}, 64'd0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("fl_valid",    {63'd0, out_valid_a}, 64'd0);
        check("fl_ill_cnt",  {56'd0, ill_cnt_a},   64'd1);
        push(32'hFE000EE3);
        check("fl_next_fmt", {61'd0, out_fmt_a},   64'd3);
        check("fl_next_imm", {32'd0, out_imm_a},   64'h0000_0000_FFFF_FFFC);

        // Flush with two entries held
        push(32'h12345037);
        in_valid = 1'b1;
        in_instr = 32'h0000007F;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid",   {63'd0, out_valid_a}, 64'd0);
        check("fl2_ill_cnt", {56'd0, ill_cnt_a},   64'd1);

        // Asynchronous reset with two entries held
        push(32'hFE512C23);
        push(32'h0000007F);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid",   {63'd0, out_valid_a},   64'd0);
        check("ar_imm",     {32'd0, out_imm_a},     64'd0);
        check("ar_fmt",     {61'd0, out_fmt_a},     64'd0);
        check("ar_ill",     {63'd0, out_illegal_a}, 64'd0);
        check("ar_ill_cnt", {56'd0, ill_cnt_a},     64'd0);
        #2;
        rst_n = 1'b1;
        push(32'h12345037);
        check("ar_first_imm", {32'd0, out_imm_a}, 64'h0000_0000_1234_5000);
        pop();

        // Saturation: 300 illegal pushes, one per cycle
        in_valid  = 1'b1;
        in_instr  = 32'h0000007F;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("sat_cnt32", {56'd0, ill_cnt_a}, 64'd255);
        check("sat_cnt64", {56'd0, ill_cnt_b}, 64'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 2, 4 and 8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, instruction present on in_instr.
REQ-006 SHALL have port in_ready, output, 1, block accepts the instruction this cycle.
REQ-007 SHALL have port in_instr, input, 32, raw RV32 instruction word.
REQ-008 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-009 SHALL have port out_valid, output, 1, head entry valid.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the head entry.
REQ-011 SHALL have port out_imm, output, XLEN, sign-extended immediate of the head entry.
REQ-012 SHALL have port out_fmt, output, 3, format code of the head entry.
REQ-013 SHALL have port out_illegal, output, 1, head entry opcode unrecognised.
REQ-014 SHALL have port ill_cnt, output, 8, saturating count of accepted illegal instructions.

Function
REQ-015 Accept (push) SHALL occur when in_valid and in_ready are both 1 at a rising edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL be 1 iff occupancy < DEPTH and flush = 0; it SHALL NOT depend on out_ready.
REQ-017 out_valid SHALL be 1 iff occupancy > 0; out_imm/out_fmt/out_illegal SHALL come from a register (no combinational path from in_instr).
REQ-018 Latency: an instruction pushed into an empty buffer at edge N SHALL appear with out_valid = 1 after edge N, i.e. in cycle N+1.
REQ-019 Entries SHALL leave in push order; simultaneous push and pop SHALL keep occupancy unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-020 Decode on opcode in_instr[6:0], imm sign bit = in_instr[31], extended to XLEN:
  - 0110011 OP: imm 0, fmt 0 (R).
  - 0010011 OP-IMM, 0000011 LOAD, 1100111 JALR: imm = sext(instr[31:20]), fmt 1 (I).
  - 0100011 STORE: imm = sext({instr[31:25], instr[11:7]}), fmt 2 (S).
  - 1100011 BRANCH: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}), fmt 3 (B).
  - 0110111 LUI, 0010111 AUIPC: imm = sext({instr[31:12], 12 zeros}) from bit 31, fmt 4 (U).
  - 1101111 JAL: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}), fmt 5 (J).
  - any other opcode: imm 0, fmt 7, illegal 1; all legal opcodes give illegal 0.
REQ-021 ill_cnt SHALL increment by 1 on each push of an illegal instruction and SHALL saturate at 255; flush SHALL NOT clear it.
REQ-022 flush = 1 at an edge SHALL set occupancy and both pointers to 0; out_valid SHALL be 0 in the following cycle; no push occurs that cycle (in_ready = 0); any pop handshake that cycle is discarded.
REQ-023 Behaviour for XLEN or DEPTH outside legal values is undefined and not verified.

Reset
REQ-024 rst_n = 0 SHALL immediately, without waiting for clk, force occupancy 0, pointers 0, out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, ill_cnt 0; in_ready SHALL be 1 while rst_n = 1 and the buffer is empty.
REQ-025 Reset asserted mid-operation SHALL discard all buffered entries; the first push after rst_n rises SHALL be output first.

Verification
REQ-026 XLEN=32: push 0xFE000EE3 -> out_imm 0xFFFFFFFC, fmt 3; push 0x8000006F -> out_imm 0xFFF00000, fmt 5; push 0x12345037 -> out_imm 0x12345000, fmt 4.
REQ-027 XLEN=64: push 0x80000037 -> out_imm 0xFFFFFFFF80000000, fmt 4; push 0xFFF00013 -> out_imm 0xFFFFFFFFFFFFFFFF, fmt 1.
REQ-028 DEPTH=2, out_ready=0, push A,B,C back-to-back -> in_ready 0 after B, C held; then out_ready=1 -> A,B,C out in order, one per cycle, and a push every cycle with a pop every cycle holds occupancy.
REQ-029 Push 0x0000007F -> fmt 7, illegal 1, imm 0, ill_cnt 1; 300 illegal pushes -> ill_cnt 255.
REQ-030 Buffer holding 2 entries, flush=1 with in_valid=1 -> next cycle out_valid 0, input not taken, ill_cnt unchanged.
REQ-031 Buffer holding 2 entries, rst_n pulsed low between edges -> out_valid 0 before the next edge, all outputs 0.
